cpu_run_monitor: RTL and testbench

Parametrised run-control and trace monitor that sits beside top_CPU in the multicycle CPU simulation environment. It replaces a fixed-length run with cycle budgeting and halt detection. It counts cycles and retired fetches, and records a circular trace of {PC, ALU_result} per fetched instruction. After the run ends, it exposes the trace oldest-first on a valid/ready drain port.

---
 rtl/cpu_run_monitor.sv | 135 +++++++++++++
 tb/tb_cpu_run_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Run control beside top_CPU: cycle budget, halt detection and a circular {PC, ALU_result} trace.
// Counters/state update one edge after the cause; the drain head is combinational and advances on rd_valid && rd_ready.
module cpu_run_monitor #(
    parameter int                AW         = 32,
    parameter int                DW         = 32,
    parameter int                DEPTH      = 16,
    parameter int                CW         = 16,
    parameter int                MAX_CYCLES = 110,
    parameter logic [AW-1:0]     HALT_ADDR  = 32'hFFFF_FFFC,
    localparam int               PW         = $clog2(DEPTH),
    localparam int               LW         = PW + 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          if_strobe,
    input  logic [AW-1:0] currentIAddr,
    input  logic [AW-1:0] nextIAddr,
    input  logic [DW-1:0] ALU_result,
    input  logic          restart,
    output logic          running,
    output logic          halted,
    output logic          timeout,
    output logic          overflow,
    output logic [CW-1:0] cycle_count,
    output logic [CW-1:0] instr_count,
    output logic [LW-1:0] trace_level,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW-1:0] rd_pc,
    output logic [DW-1:0] rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_TIMEOUT} state_t;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } entry_t;

    state_t        state_q;
    logic [CW-1:0] cycle_q;
    logic [CW-1:0] instr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    entry_t        trace_mem [DEPTH];
    entry_t        head;

    logic in_run;
    logic drain_st;
    logic capture;
    logic halt_hit;
    logic budget_hit;
    logic buf_full;
    logic rd_fire;

    assign in_run     = (state_q == S_RUN);
    assign drain_st   = (state_q == S_HALTED) || (state_q == S_TIMEOUT);
    assign capture    = in_run && if_strobe;
    assign halt_hit   = capture && ((currentIAddr == HALT_ADDR) || (nextIAddr == currentIAddr));
    assign budget_hit = in_run && (cycle_q == CW'(MAX_CYCLES - 1));
    assign buf_full   = (level_q == LW'(DEPTH));
    assign rd_fire    = rd_valid && rd_ready;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            cycle_q    <= '0;
            instr_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_q <= S_RUN;
                S_RUN: begin
                    cycle_q <= cycle_q + CW'(1);
                    if (if_strobe) begin
                        instr_q  <= instr_q + CW'(1);
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        // A full buffer drops its oldest entry to make room.
                        if (buf_full) begin
                            rd_ptr_q   <= rd_ptr_q + PW'(1);
                            overflow_q <= 1'b1;
                        end else begin
                            level_q <= level_q + LW'(1);
                        end
                    end
                    if (halt_hit) begin
                        state_q <= S_HALTED;
                    end else if (budget_hit) begin
                        state_q <= S_TIMEOUT;
                    end
                end
                S_HALTED, S_TIMEOUT: begin
                    if (restart) begin
                        state_q    <= S_RUN;
                        cycle_q    <= '0;
                        instr_q    <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        level_q    <= '0;
                        overflow_q <= 1'b0;
                    end else if (rd_fire) begin
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        level_q  <= level_q - LW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Trace storage carries no reset; validity is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (capture) begin
            trace_mem[wr_ptr_q] <= '{pc: currentIAddr, data: ALU_result};
        end
    end

    assign head        = trace_mem[rd_ptr_q];
    assign running     = in_run;
    assign halted      = (state_q == S_HALTED);
    assign timeout     = (state_q == S_TIMEOUT);
    assign overflow    = overflow_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
    assign trace_level = level_q;
    assign rd_valid    = drain_st && (level_q != '0);
    assign rd_pc       = rd_valid ? head.pc   : '0;
    assign rd_data     = rd_valid ? head.data : '0;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor (DEPTH=16, MAX_CYCLES=110); inputs driven 1ns after the rising edge.
module tb_cpu_run_monitor;

    logic        clk;
    logic        Reset;
    logic        if_strobe;
    logic [31:0] currentIAddr;
    logic [31:0] nextIAddr;
    logic [31:0] ALU_result;
    logic        restart;
    logic        running;
    logic        halted;
    logic        timeout;
    logic        overflow;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;
    logic [4:0]  trace_level;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_data;

    int n_chk = 0;
    int n_err = 0;

    cpu_run_monitor dut (
        .clk          (clk),
        .Reset        (Reset),
        .if_strobe    (if_strobe),
        .currentIAddr (currentIAddr),
        .nextIAddr    (nextIAddr),
        .ALU_result   (ALU_result),
        .restart      (restart),
        .running      (running),
        .halted       (halted),
        .timeout      (timeout),
        .overflow     (overflow),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count),
        .trace_level  (trace_level),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_pc        (rd_pc),
        .rd_data      (rd_data)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] alu);
        if_strobe    = 1'b1;
        currentIAddr = pc;
        nextIAddr    = npc;
        ALU_result   = alu;
        tick(1);
        if_strobe    = 1'b0;
    endtask

    task automatic strobe20();
        for (int i = 0; i < 20; i++) begin
            strobe(32'(i * 4), 32'(i * 4 + 4), 32'h0A00 + 32'(i));
        end
    endtask

    initial begin
        Reset        = 1'b1;
        if_strobe    = 1'b0;
        currentIAddr = '0;
        nextIAddr    = '0;
        ALU_result   = '0;
        restart      = 1'b0;
        rd_ready     = 1'b0;

        // Reset pulse and idle run
        #25;
        Reset = 1'b0;
        #1;
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_level", trace_level, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk);
        #1;
        Reset = 1'b1;
        tick(1);
        chk("run_entry", running, 1);
        chk("run_entry_cycle", cycle_count, 0);
        tick(5);
        chk("idle5_running", running, 1);
        chk("idle5_cycle", cycle_count, 5);
        chk("idle5_instr", instr_count, 0);
        chk("idle5_level", trace_level, 0);
        chk("idle5_rd_valid", rd_valid, 0);

        // Four fetches ending at HALT_ADDR
        strobe(32'h0, 32'h4, 32'd1);
        strobe(32'h4, 32'h8, 32'd2);
        strobe(32'h8, 32'hC, 32'd3);
        strobe(32'hFFFF_FFFC, 32'h0, 32'd4);
        chk("halt_halted", halted, 1);
        chk("halt_running", running, 0);
        chk("halt_instr", instr_count, 4);
        chk("halt_cycle", cycle_count, 9);
        chk("halt_level", trace_level, 4);
        rd_ready = 1'b1;
        chk("drain0_valid", rd_valid, 1);
        chk("drain0_pc", rd_pc, 32'h0);
        chk("drain0_data", rd_data, 1);
        tick(1);
        chk("drain1_pc", rd_pc, 32'h4);
        chk("drain1_data", rd_data, 2);
        tick(1);
        chk("drain2_pc", rd_pc, 32'h8);
        chk("drain2_data", rd_data, 3);
        tick(1);
        chk("drain3_pc", rd_pc, 32'hFFFF_FFFC);
        chk("drain3_data", rd_data, 4);
        tick(1);
        chk("drain_empty_valid", rd_valid, 0);
        chk("drain_empty_level", trace_level, 0);
        tick(1);
        chk("ready_idle_level", trace_level, 0);
        rd_ready = 1'b0;
        strobe(32'h40, 32'h44, 32'd9);
        chk("halted_ignore_instr", instr_count, 4);
        chk("halted_ignore_level", trace_level, 0);
        chk("halted_frozen_cycle", cycle_count, 9);

        // Run A: overflow then timeout, full drain
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("rsA_running", running, 1);
        chk("rsA_cycle", cycle_count, 0);
        strobe20();
        chk("A_instr", instr_count, 20);
        chk("A_overflow", overflow, 1);
        chk("A_level", trace_level, 16);
        tick(89);
        chk("A_pre_to_running", running, 1);
        chk("A_pre_to_cycle", cycle_count, 109);
        tick(1);
        chk("A_timeout", timeout, 1);
        chk("A_to_running", running, 0);
        chk("A_to_cycle", cycle_count, 110);
        tick(2);
        chk("A_frozen_cycle", cycle_count, 110);
        rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("A_drain_pc", rd_pc, 64'(32'h10 + 32'(j * 4)));
            chk("A_drain_data", rd_data, 64'(32'h0A04 + 32'(j)));
            tick(1);
        end
        chk("A_drain_done", rd_valid, 0);
        rd_ready = 1'b0;

        // Run B: halt on the same edge as the budget expires
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        chk("rsB_level", trace_level, 0);
        chk("rsB_overflow", overflow, 0);
        chk("rsB_instr", instr_count, 0);
        strobe20();
        tick(89);
        strobe(32'h20, 32'h20, 32'h0BBB);
        chk("B_halted", halted, 1);
        chk("B_timeout", timeout, 0);
        chk("B_cycle", cycle_count, 110);
        chk("B_instr", instr_count, 21);
        chk("B_level", trace_level, 16);
        chk("B_head_pc", rd_pc, 32'h14);
        rd_ready = 1'b1;
        tick(13);
        chk("B_mid_level", trace_level, 3);
        chk("B_mid_pc", rd_pc, 32'h48);
        Reset = 1'b0;
        #1;
        chk("B_rst_running", running, 0);
        chk("B_rst_halted", halted, 0);
        chk("B_rst_level", trace_level, 0);
        chk("B_rst_rd_valid", rd_valid, 0);
        rd_ready = 1'b0;
        @(posedge clk);
        #1;
        Reset = 1'b1;
        tick(1);
        chk("B_rel_running", running, 1);
        chk("B_rel_cycle", cycle_count, 0);
        tick(1);
        chk("B_rel_cycle1", cycle_count, 1);

        // Run C: restart from TIMEOUT with a partially drained, overflowed buffer
        strobe20();
        tick(89);
        chk("C_timeout", timeout, 1);
        chk("C_cycle", cycle_count, 110);
        rd_ready = 1'b1;
        tick(9);
        rd_ready = 1'b0;
        chk("C_level", trace_level, 7);
        chk("C_overflow", overflow, 1);
        chk("C_head_pc", rd_pc, 32'h34);
        restart = 1'b1;
        tick(1);
        chk("C_rs_running", running, 1);
        chk("C_rs_timeout", timeout, 0);
        chk("C_rs_level", trace_level, 0);
        chk("C_rs_overflow", overflow, 0);
        chk("C_rs_cycle", cycle_count, 0);
        chk("C_rs_instr", instr_count, 0);
        tick(3);
        chk("C_hold_running", running, 1);
        chk("C_hold_cycle", cycle_count, 3);
        strobe(32'h100, 32'h104, 32'h55);
        chk("C_hold_instr", instr_count, 1);
        chk("C_hold_level", trace_level, 1);
        restart = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
